// File: rtl/alu_issue_stage.sv
// Command-buffering issue stage in front of the combinational alu: a command FIFO,
// a registered issue slot driving the alu inputs, and a flow-controlled response register.
module alu_issue_stage #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [31:0]              cmd_a,
    input  logic [31:0]              cmd_b,
    input  logic [TAG_W-1:0]         cmd_tag,
    output logic [31:0]              alu_a,
    output logic [31:0]              alu_b,
    output logic [2:0]               alu_op,
    input  logic [31:0]              alu_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_result,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic                     rsp_err,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    function automatic logic op_illegal(input logic [2:0] op);
        return (op > 3'd4);
    endfunction

    logic [2:0]       mem_op_r  [DEPTH];
    logic [31:0]      mem_a_r   [DEPTH];
    logic [31:0]      mem_b_r   [DEPTH];
    logic [TAG_W-1:0] mem_tag_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    logic             iss_valid_r;
    logic [2:0]       iss_op_r;
    logic [31:0]      iss_a_r;
    logic [31:0]      iss_b_r;
    logic [TAG_W-1:0] iss_tag_r;
    logic             iss_err_r;

    logic             rsp_valid_r;
    logic [31:0]      rsp_result_r;
    logic [TAG_W-1:0] rsp_tag_r;
    logic             rsp_err_r;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;
    logic rsp_load_s;
    logic iss_adv_s;

    // Handshake decode; cmd_ready depends only on registered occupancy
    always_comb begin
        full_s     = (count_r == CW'(DEPTH));
        empty_s    = (count_r == {CW{1'b0}});
        push_s     = cmd_valid && !full_s;
        rsp_load_s = iss_valid_r && (!rsp_valid_r || rsp_ready);
        iss_adv_s  = !iss_valid_r || rsp_load_s;
        pop_s      = iss_adv_s && !empty_s;
    end

    // Command FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_op_r[i]  <= 3'd0;
                mem_a_r[i]   <= 32'd0;
                mem_b_r[i]   <= 32'd0;
                mem_tag_r[i] <= {TAG_W{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_op_r[wr_ptr_r]  <= cmd_op;
                mem_a_r[wr_ptr_r]   <= cmd_a;
                mem_b_r[wr_ptr_r]   <= cmd_b;
                mem_tag_r[wr_ptr_r] <= cmd_tag;
                wr_ptr_r            <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue slot; illegal opcodes are flagged and replaced by ADD so the alu never sees them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_r <= 1'b0;
            iss_op_r    <= 3'd0;
            iss_a_r     <= 32'd0;
            iss_b_r     <= 32'd0;
            iss_tag_r   <= {TAG_W{1'b0}};
            iss_err_r   <= 1'b0;
        end else if (iss_adv_s) begin
            if (pop_s) begin
                iss_valid_r <= 1'b1;
                iss_op_r    <= op_illegal(mem_op_r[rd_ptr_r]) ? 3'd0 : mem_op_r[rd_ptr_r];
                iss_a_r     <= mem_a_r[rd_ptr_r];
                iss_b_r     <= mem_b_r[rd_ptr_r];
                iss_tag_r   <= mem_tag_r[rd_ptr_r];
                iss_err_r   <= op_illegal(mem_op_r[rd_ptr_r]);
            end else begin
                iss_valid_r <= 1'b0;
            end
        end else begin
            iss_valid_r <= iss_valid_r;
        end
    end

    // Response register with valid/ready hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= 32'd0;
            rsp_tag_r    <= {TAG_W{1'b0}};
            rsp_err_r    <= 1'b0;
        end else if (rsp_load_s) begin
            rsp_valid_r  <= 1'b1;
            rsp_result_r <= iss_err_r ? 32'd0 : alu_result;
            rsp_tag_r    <= iss_tag_r;
            rsp_err_r    <= iss_err_r;
        end else if (rsp_valid_r && rsp_ready) begin
            rsp_valid_r  <= 1'b0;
        end else begin
            rsp_valid_r  <= rsp_valid_r;
        end
    end

    assign cmd_ready  = !full_s;
    assign alu_a      = iss_a_r;
    assign alu_b      = iss_b_r;
    assign alu_op     = iss_op_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = rsp_result_r;
    assign rsp_tag    = rsp_tag_r;
    assign rsp_err    = rsp_err_r;
    assign fifo_count = count_r;
    assign busy       = !empty_s || iss_valid_r || rsp_valid_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural alu closing the loop.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [3:0]  cmd_tag;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_tag;
    logic        rsp_err;
    logic [2:0]  fifo_count;
    logic        busy;

    int vec = 0;
    int mis = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return 32'hdead_beef;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_a, alu_b, alu_op);

    alu_issue_stage #(.DEPTH(4), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err), .fifo_count(fifo_count), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 32'd0; cmd_b = 32'd0;
        cmd_tag = 4'd0; rsp_ready = 1'b0;
        #3;
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1) begin
                rsp_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 32'(50 + i); cmd_b = 32'd1;
                    cmd_tag = 4'(i + 5);
                    tick();
                end
                cmd_valid = 1'b0;
                vec++;
                if ({rsp_valid, fifo_count} !== {1'b1, 3'd1}) begin
                    mis++; $display("FAIL pre_reset_fill: valid/count=%b/%0d expected 1/1", rsp_valid, fifo_count);
                end
                #2 rst_n = 1'b0;
                #1;
            end
            vec++;
            if ({cmd_ready, rsp_valid, rsp_err, busy} !== 4'b1000) begin
                mis++; $display("FAIL reset_ctrl%0d: ready/valid/err/busy=%b expected 1000", ph,
                                {cmd_ready, rsp_valid, rsp_err, busy});
            end
            vec++;
            if (fifo_count !== 3'd0) begin
                mis++; $display("FAIL reset_count%0d: got %0d expected 0", ph, fifo_count);
            end
            vec++;
            if ({alu_a, alu_b, alu_op} !== 67'd0) begin
                mis++; $display("FAIL reset_alu%0d: a=%h b=%h op=%0d expected zeros", ph, alu_a, alu_b, alu_op);
            end
            vec++;
            if ({rsp_result, rsp_tag} !== 36'd0) begin
                mis++; $display("FAIL reset_rsp%0d: result=%h tag=%0d expected zeros", ph, rsp_result, rsp_tag);
            end
            tick();
            rst_n = 1'b1;
            rsp_ready = 1'b1;
            for (int i = 0; i < 5; i++) begin
                tick();
                vec++;
                if ({rsp_valid, busy} !== 2'b00) begin
                    mis++; $display("FAIL reset_no_stale%0d: valid/busy=%b expected 00", ph, {rsp_valid, busy});
                end
            end
        end
    endtask

    task automatic test_opcodes();
        logic [31:0] exp_res [5];
        exp_res = '{32'd25, 32'd5, 32'd10, 32'd15, 32'd5};
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_op = 3'(i); cmd_a = 32'd15; cmd_b = 32'd10; cmd_tag = 4'(i + 1);
            tick();
            cmd_valid = 1'b0;
            vec++;
            if (rsp_valid !== 1'b0) begin
                mis++; $display("FAIL op%0d_lat0: rsp_valid=%b expected 0", i, rsp_valid);
            end
            tick();
            vec++;
            if ({rsp_valid, alu_op} !== {1'b0, 3'(i)}) begin
                mis++; $display("FAIL op%0d_lat1: valid=%b alu_op=%0d expected 0/%0d", i, rsp_valid, alu_op, i);
            end
            tick();
            vec++;
            if ({rsp_valid, rsp_result, rsp_tag, rsp_err} !== {1'b1, exp_res[i], 4'(i + 1), 1'b0}) begin
                mis++; $display("FAIL op%0d_rsp: valid=%b result=%0d tag=%0d err=%b expected 1/%0d/%0d/0",
                                i, rsp_valid, rsp_result, rsp_tag, rsp_err, exp_res[i], i + 1);
            end
            tick();
            vec++;
            if ({rsp_valid, busy} !== 2'b00) begin
                mis++; $display("FAIL op%0d_drain: valid/busy=%b expected 00", i, {rsp_valid, busy});
            end
        end
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) begin
                cmd_valid = 1'b1; cmd_op = 3'(i % 5); cmd_a = 32'(i * 1000 + 5);
                cmd_b = 32'(i * 3 + 1); cmd_tag = 4'(i);
                vec++;
                if (cmd_ready !== 1'b1) begin
                    mis++; $display("FAIL b2b_ready%0d: cmd_ready=%b expected 1", i, cmd_ready);
                end
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            if (i >= 2 && i <= 9) begin
                vec++;
                if ({rsp_valid, rsp_tag, rsp_err, rsp_result} !==
                    {1'b1, 4'(i - 2), 1'b0, alu_ref(32'((i - 2) * 1000 + 5), 32'((i - 2) * 3 + 1), 3'((i - 2) % 5))}) begin
                    mis++; $display("FAIL b2b_rsp%0d: valid=%b tag=%0d err=%b result=%0d expected tag %0d",
                                    i - 2, rsp_valid, rsp_tag, rsp_err, rsp_result, i - 2);
                end
            end else if (i > 9) begin
                vec++;
                if (rsp_valid !== 1'b0) begin
                    mis++; $display("FAIL b2b_tail%0d: rsp_valid=%b expected 0", i, rsp_valid);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        int got = 0;
        rsp_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 32'(100 + accepted);
            cmd_b = 32'(accepted); cmd_tag = 4'(accepted);
            if (!cmd_ready) break;
            tick();
            accepted++;
            if (rsp_valid) begin
                vec++;
                if ({rsp_tag, rsp_result, alu_a} !== {4'd0, 32'd100, 32'd101}) begin
                    mis++; $display("FAIL bp_stable_fill: tag=%0d result=%0d alu_a=%0d expected 0/100/101",
                                    rsp_tag, rsp_result, alu_a);
                end
            end
        end
        vec++;
        if ({accepted, fifo_count, cmd_ready} !== {32'd6, 3'd4, 1'b0}) begin
            mis++; $display("FAIL bp_full: accepted=%0d count=%0d ready=%b expected 6/4/0",
                            accepted, fifo_count, cmd_ready);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            vec++;
            if ({fifo_count, cmd_ready, rsp_tag, rsp_result, alu_a, alu_b} !==
                {3'd4, 1'b0, 4'd0, 32'd100, 32'd101, 32'd1}) begin
                mis++; $display("FAIL bp_hold%0d: count=%0d ready=%b tag=%0d result=%0d alu_a=%0d", c,
                                fifo_count, cmd_ready, rsp_tag, rsp_result, alu_a);
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        vec++;
        if (cmd_ready !== 1'b0) begin
            mis++; $display("FAIL bp_ready_path: cmd_ready=%b expected 0 before the pop edge", cmd_ready);
        end
        for (int c = 0; c < 20 && got < 6; c++) begin
            if (rsp_valid) begin
                vec++;
                if ({rsp_tag, rsp_result, rsp_err} !== {4'(got), 32'(100 + 2 * got), 1'b0}) begin
                    mis++; $display("FAIL bp_drain%0d: tag=%0d result=%0d err=%b expected %0d/%0d/0",
                                    got, rsp_tag, rsp_result, rsp_err, got, 100 + 2 * got);
                end
                got++;
            end
            tick();
        end
        vec++;
        if ({got, busy} !== {32'd6, 1'b0}) begin
            mis++; $display("FAIL bp_drain_count: got=%0d busy=%b expected 6/0", got, busy);
        end
    endtask

    task automatic test_illegal();
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = 3'b110; cmd_a = 32'd7; cmd_b = 32'd3; cmd_tag = 4'd9;
        tick();
        cmd_valid = 1'b0;
        tick();
        vec++;
        if ({alu_op, alu_a, alu_b} !== {3'd0, 32'd7, 32'd3}) begin
            mis++; $display("FAIL ill_alu: op=%0d a=%0d b=%0d expected 0/7/3", alu_op, alu_a, alu_b);
        end
        tick();
        vec++;
        if ({rsp_valid, rsp_result, rsp_err, rsp_tag} !== {1'b1, 32'd0, 1'b1, 4'd9}) begin
            mis++; $display("FAIL ill_rsp: valid=%b result=%0d err=%b tag=%0d expected 1/0/1/9",
                            rsp_valid, rsp_result, rsp_err, rsp_tag);
        end
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 32'd1; cmd_b = 32'd2; cmd_tag = 4'd3;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        vec++;
        if ({rsp_valid, rsp_result, rsp_err, rsp_tag} !== {1'b1, 32'd3, 1'b0, 4'd3}) begin
            mis++; $display("FAIL ill_next: valid=%b result=%0d err=%b tag=%0d expected 1/3/0/3",
                            rsp_valid, rsp_result, rsp_err, rsp_tag);
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [31:0] q_res [$];
        logic [3:0]  q_tag [$];
        logic        q_err [$];
        int sent = 0;
        int recv = 0;
        for (int c = 0; c < 600 && recv < 12; c++) begin
            rsp_ready = 1'($urandom_range(0, 1));
            if (sent < 12) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op = 3'($urandom_range(0, 7));
                cmd_a = $urandom; cmd_b = $urandom; cmd_tag = 4'(sent);
            end else begin
                cmd_valid = 1'b0;
            end
            if (rsp_valid && rsp_ready) begin
                vec++;
                if (q_res.size() == 0) begin
                    mis++; $display("FAIL wrap_extra: unexpected response tag=%0d", rsp_tag);
                end else begin
                    if ({rsp_result, rsp_tag, rsp_err} !== {q_res[0], q_tag[0], q_err[0]}) begin
                        mis++; $display("FAIL wrap_rsp%0d: result=%h tag=%0d err=%b expected %h/%0d/%b",
                                        recv, rsp_result, rsp_tag, rsp_err, q_res[0], q_tag[0], q_err[0]);
                    end
                    void'(q_res.pop_front()); void'(q_tag.pop_front()); void'(q_err.pop_front());
                end
                recv++;
            end
            if (cmd_valid && cmd_ready) begin
                q_res.push_back(cmd_op > 3'd4 ? 32'd0 : alu_ref(cmd_a, cmd_b, cmd_op));
                q_tag.push_back(cmd_tag);
                q_err.push_back(cmd_op > 3'd4);
                sent++;
            end
            vec++;
            if (fifo_count > 3'd4) begin
                mis++; $display("FAIL wrap_count: fifo_count=%0d exceeds 4", fifo_count);
            end
            tick();
        end
        cmd_valid = 1'b0;
        vec++;
        if ({recv, q_res.size()} !== {32'd12, 32'd0}) begin
            mis++; $display("FAIL wrap_total: received=%0d pending=%0d expected 12/0", recv, q_res.size());
        end
    endtask

    initial begin
        test_reset();
        test_opcodes();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
